// File: rtl/hack_pkg.sv
// Shared HACK definitions: loader state encoding and default memory geometry
// (the DEPTH constant is also used by the RAM16K wrapper).
package hack_pkg;

  localparam int unsigned HACK_ADDR_W = 15;
  localparam int unsigned HACK_DATA_W = 16;
  localparam int unsigned HACK_DEPTH  = 16384;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } load_state_t;

endpackage : hack_pkg

// File: rtl/hack_load_accum.sv
// Word counter and modular checksum accumulator for the program loader.
// Clear has priority over enable.
module hack_load_accum #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [DATA_W-1:0] o_sum
);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_sum <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sum <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_sum <= r_sum + i_data;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sum = r_sum;

endmodule : hack_load_accum

// File: rtl/hack_prog_loader.sv
// HACK program-load controller: streams words into instruction memory at a
// base address, holds the CPU in reset while loading, then hands over to the PC.
module hack_prog_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W = HACK_ADDR_W,
  parameter int unsigned DATA_W = HACK_DATA_W,
  parameter int unsigned DEPTH  = HACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W:0]   len_in,
  input  logic              run,
  input  logic              abort,
  input  logic              cpu_rst_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);

  load_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic              r_err;
  logic              r_done;

  logic [ADDR_W+1:0] w_end;
  logic              w_range_ok;
  logic              w_start_en;
  logic              w_start_acc;
  logic              w_start_rej;
  logic              w_accept;
  logic              w_last;
  logic [ADDR_W:0]   w_cnt;
  logic [DATA_W-1:0] w_sum;

  // Range check is done two bits wider than the address so base+len cannot wrap.
  assign w_end       = {2'b00, base_in} + {1'b0, len_in};
  assign w_range_ok  = (w_end <= DEPTH_EXT) && ({1'b0, len_in} <= DEPTH_EXT);
  assign w_start_en  = start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_start_acc = w_start_en && w_range_ok;
  assign w_start_rej = w_start_en && !w_range_ok;

  assign w_accept = (r_state == ST_LOAD) && s_valid && !abort;
  assign w_last   = w_accept && (w_cnt == (r_len - LEN_ONE));

  hack_load_accum #(
    .CNT_W (ADDR_W + 1),
    .DATA_W(DATA_W)
  ) u_accum (
    .clk    (clk),
    .i_rst_n(rst),
    .i_clr  (w_start_acc),
    .i_en   (w_accept),
    .i_data (s_data),
    .o_cnt  (w_cnt),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = (len_in == '0) ? ST_DRAIN : ST_LOAD;
        end else if (run && !start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (w_start_acc) begin
          w_state_nxt = (len_in == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && !abort;
      if (w_start_acc) begin
        r_base <= base_in;
        r_len  <= len_in;
        r_err  <= 1'b0;
      end else if (w_start_rej) begin
        r_err  <= 1'b1;
      end
    end
  end

  assign s_ready  = (r_state == ST_LOAD);
  assign rom_we   = w_accept;
  assign rom_data = s_data;
  assign rom_addr = (r_state == ST_LOAD) ? (r_base + w_cnt[ADDR_W-1:0]) : pc_in;
  assign cpu_rst  = (r_state != ST_RUN) || cpu_rst_req;
  assign busy     = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign done     = r_done;
  assign err      = r_err;
  assign checksum = w_sum;
  assign word_cnt = w_cnt;

endmodule : hack_prog_loader

// File: tb/tb_hack_prog_loader.sv
// Directed-plus-random bench for hack_prog_loader; expected memory contents,
// checksums and counts come from a simple array/queue model of the load.
module tb_hack_prog_loader;

  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 16;
  localparam int unsigned DEP = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [AW:0]   len_in = '0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          cpu_rst_req = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [AW-1:0] pc_in = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_we;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] checksum;
  logic [AW:0]   word_cnt;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [DW-1:0] mem_dut [DEP];
  logic [DW-1:0] wq [$];

  hack_prog_loader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_in    (base_in),
    .len_in     (len_in),
    .run        (run),
    .abort      (abort),
    .cpu_rst_req(cpu_rst_req),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .pc_in      (pc_in),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_we     (rom_we),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  // Memory behaves as a synchronous-write RAM; capture mid-cycle.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      if (rom_addr < AW'(DEP)) mem_dut[rom_addr] <= rom_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads wq[0..len-1] at base; mode 0 = valid held, 1 = alternating, 2 = random.
  task automatic run_load(input int base, input int len, input int mode);
    int idx = 0;
    int budget = 0;
    int w0 = wr_cnt;
    logic v;
    logic [DW-1:0] sum = '0;
    for (int i = 0; i < len; i++) sum = sum + wq[i];
    start = 1'b1; base_in = AW'(base); len_in = (AW+1)'(len);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    chk("cnt_cleared", word_cnt, 0);
    while (idx < len && budget < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((budget % 2) == 0) : 1'($urandom_range(0, 1));
      s_valid = v; s_data = wq[idx];
      #1;
      chk("load_ready", s_ready, 1);
      chk("load_we", rom_we, v);
      chk("load_addr", rom_addr, base + idx);
      chk("load_cpu_rst", cpu_rst, 1);
      tick();
      if (v) idx++;
      budget++;
    end
    s_valid = 1'b1; s_data = 16'hDEAD;
    if (idx < len) chk("load_timeout", idx, len);
    #1;
    chk("drain_busy", busy, 1);
    chk("drain_ready", s_ready, 0);
    chk("drain_we", rom_we, 0);
    chk("drain_done", done, 0);
    tick();
    s_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("run_busy", busy, 0);
    chk("run_cpu_rst", cpu_rst, 0);
    chk("checksum", checksum, sum);
    chk("word_cnt", word_cnt, len);
    chk("write_count", wr_cnt - w0, len);
    for (int i = 0; i < len; i++) chk("mem_word", mem_dut[base + i], wq[i]);
    tick();
    chk("done_single", done, 0);
  endtask

  initial begin
    int b, n, w0;
    logic [DW-1:0] part;

    // Reset
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_sum", checksum, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ready", s_ready, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: run from IDLE
    pc_in = 15'h0005;
    #1;
    chk("idle_addr", rom_addr, 15'h0005);
    chk("idle_cpu_rst", cpu_rst, 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run_cpu_rst_low", cpu_rst, 0);
    chk("run_addr", rom_addr, 15'h0005);
    pc_in = AW'($urandom);
    #1;
    chk("run_addr_follow", rom_addr, pc_in);

    // 2: fixed three-word load
    wq = '{16'h1111, 16'h2222, 16'h0001};
    run_load(16'h0010, 3, 0);

    // 3: range error, then boundary-exact accepted load
    w0 = wr_cnt;
    start = 1'b1; base_in = 15'h3FFE; len_in = 16'd3;
    tick();
    start = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_state_run", cpu_rst, 0);
    chk("rej_sum_held", checksum, 16'h3334);
    chk("rej_cnt_held", word_cnt, 3);
    start = 1'b1; base_in = 15'h0000; len_in = 16'd16385;
    tick();
    start = 1'b0;
    chk("rej_len_err", err, 1);
    chk("rej_writes", wr_cnt - w0, 0);
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(DW'($urandom));
    run_load(16'h3FFD, 3, 2);

    // 4: alternating valid
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(DW'($urandom));
    run_load(16'h0200, 4, 1);

    // zero-length load goes straight through DRAIN
    wq.delete();
    run_load(16'h0300, 0, 0);

    // 5: abort after 2 of 5 words; a start mid-load must be ignored
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(DW'($urandom));
    b = int'($urandom_range(0, DEP - 5));
    w0 = wr_cnt;
    start = 1'b1; base_in = AW'(b); len_in = 16'd5;
    tick();
    start = 1'b1; base_in = 15'h2000; len_in = 16'd1;
    s_valid = 1'b1; s_data = wq[0];
    tick();
    start = 1'b0;
    s_data = wq[1];
    tick();
    abort = 1'b1; s_data = wq[2];
    #1;
    chk("abort_no_we", rom_we, 0);
    chk("abort_addr", rom_addr, b + 2);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    part = wq[0] + wq[1];
    chk("abort_busy", busy, 0);
    chk("abort_cnt", word_cnt, 2);
    chk("abort_sum", checksum, part);
    chk("abort_cpu_rst", cpu_rst, 1);
    chk("abort_done", done, 0);
    chk("abort_writes", wr_cnt - w0, 2);
    tick();
    chk("abort_done_later", done, 0);
    chk("abort_idle_addr", rom_addr, pc_in);

    // random loads from IDLE/RUN
    for (int k = 0; k < 5; k++) begin
      n = int'($urandom_range(1, 8));
      b = int'($urandom_range(0, DEP - n));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
      run_load(b, n, 2);
    end

    // 6: async reset mid-LOAD, then cpu_rst_req in RUN
    start = 1'b1; base_in = 15'h0100; len_in = 16'd4;
    tick();
    start = 1'b0;
    s_valid = 1'b1; s_data = 16'hBEEF;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt", word_cnt, 0);
    chk("arst_sum", checksum, 0);
    chk("arst_err", err, 0);
    chk("arst_done", done, 0);
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_ready", s_ready, 0);
    chk("arst_we", rom_we, 0);
    chk("arst_addr", rom_addr, pc_in);
    s_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", cpu_rst, 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run2_cpu_rst", cpu_rst, 0);
    cpu_rst_req = 1'b1;
    #1;
    chk("req_cpu_rst", cpu_rst, 1);
    tick();
    chk("req_busy", busy, 0);
    chk("req_cpu_rst_hold", cpu_rst, 1);
    cpu_rst_req = 1'b0;
    #1;
    chk("req_release", cpu_rst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hack_prog_loader
